alu_mc: RTL

//   Parametrised multi-cycle ALU; successor to the single-cycle datapath ALU. Logic, arithmetic,

---
 rtl/alu_mc_pkg.sv | 30 +++
 rtl/alu_mc_if.sv | 18 +
 rtl/alu_mc_seq_muldiv.sv | 76 +++++++
 rtl/alu_mc.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding and a small
// opcode-class helper.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_NEG  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SHRA = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Start/done handshake and result bundle between the control unit and alu_mc.
interface alu_mc_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             carry;
    logic             div_by_zero;

    modport master (output start, op, a, b,
                    input  busy, done, lo, hi, carry, div_by_zero);
    modport slave  (input  start, op, a, b,
                    output busy, done, lo, hi, carry, div_by_zero);
endinterface

// File: rtl/alu_mc_seq_muldiv.sv
// Iterative unsigned magnitude core: shift-add multiply or restoring divide,
// one radix-2 step per cycle for WIDTH cycles after go.
module alu_seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] ma,
    input  logic [WIDTH-1:0] mb,
    output logic             rdy,
    output logic [WIDTH-1:0] p_hi,
    output logic [WIDTH-1:0] p_lo
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_r, q_r, mb_r, acc_nxt_s, q_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r, div_r;
    logic [WIDTH:0]   sum_s, shl_s, diff_s;

    // One iteration step; acc holds the product upper half or the partial remainder
    always_comb begin
        sum_s  = {1'b0, acc_r} + {1'b0, mb_r};
        shl_s  = {acc_r, q_r[WIDTH-1]};
        diff_s = shl_s - {1'b0, mb_r};
        if (div_r) begin
            if (!diff_s[WIDTH]) begin
                acc_nxt_s = diff_s[WIDTH-1:0];
                q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = shl_s[WIDTH-1:0];
                q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (q_r[0]) begin
                acc_nxt_s = sum_s[WIDTH:1];
                q_nxt_s   = {sum_s[0], q_r[WIDTH-1:1]};
            end else begin
                acc_nxt_s = {1'b0, acc_r[WIDTH-1:1]};
                q_nxt_s   = {acc_r[0], q_r[WIDTH-1:1]};
            end
        end
    end

    // Operand latch on go, then WIDTH iteration steps
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
            q_r   <= '0;
            mb_r  <= '0;
            cnt_r <= '0;
            run_r <= 1'b0;
            div_r <= 1'b0;
        end else if (go) begin
            acc_r <= '0;
            q_r   <= ma;
            mb_r  <= mb;
            div_r <= is_div;
            cnt_r <= CNT_W'(WIDTH - 1);
            run_r <= 1'b1;
        end else if (run_r) begin
            acc_r <= acc_nxt_s;
            q_r   <= q_nxt_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == '0) begin
                run_r <= 1'b0;
            end
        end
    end

    assign rdy  = run_r && (cnt_r == '0);
    assign p_hi = acc_r;
    assign p_lo = q_r;
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: single-cycle ops computed directly, signed MUL/DIV via
// sign stripping around the iterative core, with an IDLE/ITER/FIX control FSM.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic     clk,
    input logic     reset,
    alu_mc_if.slave bus
);
    state_t             state_r, state_nxt_s;
    logic               accept_s, go_s, rdy_s, b_zero_s, is_div_op_s;
    logic               write_lo_s, carry_s;
    logic [WIDTH-1:0]   res_s, ma_s, mb_s, p_hi_s, p_lo_s, fix_lo_s, fix_hi_s;
    logic [WIDTH:0]     add_s, sub_s;
    logic [2*WIDTH-1:0] rot_s, prod_s, prod_neg_s;
    logic [SHAMT_W-1:0] sh_s;
    logic [WIDTH-1:0]   lo_r, hi_r;
    logic               carry_r, dz_r, done_r, busy_r;
    logic               neg_lo_r, neg_hi_r, is_div_r;

    // Single-cycle datapath and operand magnitudes for the core
    always_comb begin
        sh_s        = bus.b[SHAMT_W-1:0];
        add_s       = {1'b0, bus.a} + {1'b0, bus.b};
        sub_s       = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        rot_s       = (bus.op == OP_ROL) ? ({bus.a, bus.a} << sh_s) : ({bus.a, bus.a} >> sh_s);
        ma_s        = bus.a[WIDTH-1] ? -bus.a : bus.a;
        mb_s        = bus.b[WIDTH-1] ? -bus.b : bus.b;
        b_zero_s    = (bus.b == '0);
        is_div_op_s = (bus.op == OP_DIV);
        res_s       = '0;
        carry_s     = 1'b0;
        write_lo_s  = 1'b1;
        case (bus.op)
            OP_ADD:  begin res_s = add_s[WIDTH-1:0]; carry_s = add_s[WIDTH]; end
            OP_SUB:  begin res_s = sub_s[WIDTH-1:0]; carry_s = sub_s[WIDTH]; end
            OP_AND:  res_s = bus.a & bus.b;
            OP_OR:   res_s = bus.a | bus.b;
            OP_XOR:  res_s = bus.a ^ bus.b;
            OP_NOT:  res_s = ~bus.a;
            OP_NEG:  res_s = -bus.a;
            OP_SHL:  res_s = bus.a << sh_s;
            OP_SHR:  res_s = bus.a >> sh_s;
            OP_SHRA: res_s = $signed(bus.a) >>> sh_s;
            OP_ROL:  res_s = rot_s[2*WIDTH-1:WIDTH];
            OP_ROR:  res_s = rot_s[WIDTH-1:0];
            default: write_lo_s = 1'b0;
        endcase
    end

    // Sign restoration applied in FIX
    always_comb begin
        prod_s     = {p_hi_s, p_lo_s};
        prod_neg_s = -prod_s;
        if (is_div_r) begin
            fix_lo_s = neg_lo_r ? -p_lo_s : p_lo_s;
            fix_hi_s = neg_hi_r ? -p_hi_s : p_hi_s;
        end else begin
            fix_lo_s = neg_lo_r ? prod_neg_s[WIDTH-1:0] : p_lo_s;
            fix_hi_s = neg_lo_r ? prod_neg_s[2*WIDTH-1:WIDTH] : p_hi_s;
        end
    end

    // FSM next state and core launch
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = bus.start && (state_r == ST_IDLE);
        go_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_muldiv(bus.op) && !(is_div_op_s && b_zero_s)) begin
                    go_s        = 1'b1;
                    state_nxt_s = ST_ITER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (rdy_s) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result, flag and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r     <= '0;
            hi_r     <= '0;
            carry_r  <= 1'b0;
            dz_r     <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            is_div_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nxt_s != ST_IDLE);
            if (accept_s) begin
                carry_r <= carry_s;
                dz_r    <= 1'b0;
                if (write_lo_s) begin
                    lo_r   <= res_s;
                    done_r <= 1'b1;
                end else if (is_div_op_s && b_zero_s) begin
                    lo_r   <= '1;
                    hi_r   <= bus.a;
                    dz_r   <= 1'b1;
                    done_r <= 1'b1;
                end else if (go_s) begin
                    neg_lo_r <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_hi_r <= bus.a[WIDTH-1];
                    is_div_r <= is_div_op_s;
                end else begin
                    // Unknown opcode: results held, handshake still completes
                    done_r <= 1'b1;
                end
            end else if (state_r == ST_FIX) begin
                lo_r   <= fix_lo_s;
                hi_r   <= fix_hi_s;
                done_r <= 1'b1;
            end
        end
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .go     (go_s),
        .is_div (is_div_op_s),
        .ma     (ma_s),
        .mb     (mb_s),
        .rdy    (rdy_s),
        .p_hi   (p_hi_s),
        .p_lo   (p_lo_s)
    );

    assign bus.lo          = lo_r;
    assign bus.hi          = hi_r;
    assign bus.carry       = carry_r;
    assign bus.div_by_zero = dz_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
endmodule
